// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request feeding a small decode queue.
// Define FETCH_PREFETCH_EN for a two-entry queue that keeps fetching while decode stalls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0004,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir_data,
    output logic [31:0] ir_pc
);

`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] QD = 2'd2;
`else
    localparam logic [1:0] QD = 2'd1;
`endif

    typedef enum logic [0:0] {StFetch, StDrain} state_e;

    state_e      state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drain_addr_q;
    logic [31:0] head_pc_q, head_instr_q;
`ifdef FETCH_PREFETCH_EN
    logic [31:0] tail_pc_q, tail_instr_q;
`endif
    logic        fetch_req;
    logic        push;
    logic        pop;

    // Request eligibility looks at the registered count only, never a same-cycle pop.
    assign fetch_req = (count_q < QD);
    assign push      = (state_q == StFetch) && mem_req && mem_ack && !br_valid;
    assign pop       = ir_valid && ir_ready && !br_valid;
    assign ir_pc     = head_pc_q;
    assign ir_data   = head_instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: if (br_valid && fetch_req && !mem_ack) state_d = StDrain;
            StDrain: if (mem_ack) state_d = StFetch;
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = fetch_pc_q;
        case (state_q)
            StFetch: mem_req = fetch_req;
            StDrain: begin
                // Keep the abandoned request stable until memory answers it.
                mem_req  = 1'b1;
                mem_addr = drain_addr_q;
            end
            default: mem_req = 1'b0;
        endcase
        if (rst) mem_req = 1'b0;
        ir_valid = (count_q != 2'd0) && !rst;
    end

    always_comb begin
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        if (br_valid) begin
            count_d    = 2'd0;
            fetch_pc_d = br_target & 32'hFFFF_FFFC;
        end else begin
            if (push) fetch_pc_d = fetch_pc_q + PC_STEP;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= 2'd0;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= 32'd0;
            head_pc_q    <= 32'd0;
            head_instr_q <= 32'd0;
`ifdef FETCH_PREFETCH_EN
            tail_pc_q    <= 32'd0;
            tail_instr_q <= 32'd0;
`endif
        end else begin
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            if (state_q == StFetch && state_d == StDrain) drain_addr_q <= fetch_pc_q;
            if (push && (count_q == 2'd0 || pop)) begin
                head_pc_q    <= fetch_pc_q;
                head_instr_q <= mem_rdata;
            end
`ifdef FETCH_PREFETCH_EN
            else if (pop && count_q == 2'd2) begin
                head_pc_q    <= tail_pc_q;
                head_instr_q <= tail_instr_q;
            end
            if (push && !pop && count_q == 2'd1) begin
                tail_pc_q    <= fetch_pc_q;
                tail_instr_q <= mem_rdata;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a random run against a queue model.
`timescale 1ns/1ps
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam int QD = 2;
`else
    localparam int QD = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        br_valid;
    logic [31:0] br_target;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;
    logic [31:0] salt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Memory contents are a hash of the address so every word is distinguishable.
    assign mem_rdata = (mem_addr * 32'h9E37_79B1) ^ salt;

    fetch_unit dut (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .br_valid (br_valid),
        .br_target(br_target),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .ir_data  (ir_data),
        .ir_pc    (ir_pc)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; br_valid = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b1; br_valid = 1'b0; ir_ready = 1'b1; salt = $urandom;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ir_valid); end
        n_cmp++; if (ir_pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", ir_pc); end
        n_cmp++; if (ir_data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", ir_data); end
        next_cycle();
    endtask

    task automatic test_sequential();
        logic        exp_req, exp_valid;
        logic [31:0] exp_addr, exp_pc;
        do_reset();
        salt = $urandom; rst = 1'b0; mem_ack = 1'b1; ir_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            exp_req   = (QD == 2) || (n % 2 == 0);
            exp_addr  = (QD == 2) ? 32'(4 + 4 * n) : 32'(4 + 4 * (n / 2));
            exp_valid = (QD == 2) ? (n >= 1) : (n % 2 == 1);
            exp_pc    = (QD == 2) ? 32'(4 * n) : 32'(4 + 4 * (n / 2));
            n_cmp++; if (mem_req !== exp_req) begin n_bad++; $display("FAIL seq_req[%0d]: got %b want %b", n, mem_req, exp_req); end
            if (exp_req) begin
                n_cmp++; if (mem_addr !== exp_addr) begin n_bad++; $display("FAIL seq_addr[%0d]: got %h want %h", n, mem_addr, exp_addr); end
            end
            n_cmp++; if (ir_valid !== exp_valid) begin n_bad++; $display("FAIL seq_valid[%0d]: got %b want %b", n, ir_valid, exp_valid); end
            if (exp_valid) begin
                n_cmp++; if (ir_pc !== exp_pc) begin n_bad++; $display("FAIL seq_pc[%0d]: got %h want %h", n, ir_pc, exp_pc); end
                n_cmp++; if (ir_data !== word_at(exp_pc)) begin n_bad++; $display("FAIL seq_data[%0d]: got %h want %h", n, ir_data, word_at(exp_pc)); end
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc, exp_addr;
        do_reset();
        salt = $urandom; rst = 1'b0; mem_ack = 1'b1; ir_ready = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_full: got %b want 0", mem_req); end
        n_cmp++; if (ir_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", ir_valid); end
        n_cmp++; if (ir_pc !== 32'h4) begin n_bad++; $display("FAIL bp_pc_hold: got %h want 4", ir_pc); end
        n_cmp++; if (ir_data !== word_at(32'h4)) begin n_bad++; $display("FAIL bp_data_hold: got %h want %h", ir_data, word_at(32'h4)); end
        next_cycle();
        ir_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (ir_pc !== 32'h4) begin n_bad++; $display("FAIL bp_pop0_pc: got %h want 4", ir_pc); end
        next_cycle();
        @(negedge clk);
        exp_pc   = (QD == 2) ? 32'h8 : 32'h4;
        exp_addr = (QD == 2) ? 32'hC : 32'h8;
        n_cmp++; if (ir_valid !== (QD == 2)) begin n_bad++; $display("FAIL bp_pop1_valid: got %b want %b", ir_valid, QD == 2); end
        n_cmp++; if (ir_pc !== exp_pc) begin n_bad++; $display("FAIL bp_pop1_pc: got %h want %h", ir_pc, exp_pc); end
        n_cmp++; if (ir_data !== word_at(exp_pc)) begin n_bad++; $display("FAIL bp_pop1_data: got %h want %h", ir_data, word_at(exp_pc)); end
        n_cmp++; if (mem_addr !== exp_addr || mem_req !== 1'b1) begin n_bad++; $display("FAIL bp_refill: got req %b addr %h want req 1 addr %h", mem_req, mem_addr, exp_addr); end
        next_cycle();
        @(negedge clk);
        exp_pc = (QD == 2) ? 32'hC : 32'h8;
        n_cmp++; if (ir_pc !== exp_pc || ir_valid !== 1'b1) begin n_bad++; $display("FAIL bp_next_pc: got %h/%b want %h/1", ir_pc, ir_valid, exp_pc); end
        next_cycle();
    endtask

    task automatic test_branch_drain();
        do_reset();
        salt = $urandom; rst = 1'b0; mem_ack = 1'b0; ir_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_bad++; $display("FAIL drain_c0: got %b/%h want 1/4", mem_req, mem_addr); end
        next_cycle();
        br_valid = 1'b1; br_target = 32'h103;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_bad++; $display("FAIL drain_c1: got %b/%h want 1/4", mem_req, mem_addr); end
        next_cycle();
        br_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_bad++; $display("FAIL drain_hold: got %b/%h want 1/4", mem_req, mem_addr); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid: got %b want 0", ir_valid); end
        next_cycle();
        mem_ack = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_bad++; $display("FAIL drain_ack: got %b/%h want 1/4", mem_req, mem_addr); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_bad++; $display("FAIL drain_target: got %b/%h want 1/100", mem_req, mem_addr); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_bad++; $display("FAIL drain_discard: got %b want 0", ir_valid); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b1 || ir_pc !== 32'h100) begin n_bad++; $display("FAIL drain_ir: got %b/%h want 1/100", ir_valid, ir_pc); end
        n_cmp++; if (ir_data !== word_at(32'h100)) begin n_bad++; $display("FAIL drain_data: got %h want %h", ir_data, word_at(32'h100)); end
        next_cycle();
    endtask

    task automatic test_branch_ack();
        do_reset();
        salt = $urandom; rst = 1'b0; mem_ack = 1'b1; ir_ready = 1'b1;
        br_valid = 1'b1; br_target = 32'h40;
        next_cycle();
        br_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_bad++; $display("FAIL brack_addr: got %b/%h want 1/40", mem_req, mem_addr); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_bad++; $display("FAIL brack_nopush: got %b want 0", ir_valid); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b1 || ir_pc !== 32'h40) begin n_bad++; $display("FAIL brack_ir: got %b/%h want 1/40", ir_valid, ir_pc); end
        next_cycle();
    endtask

    task automatic test_wrap();
        do_reset();
        salt = $urandom; rst = 1'b0; mem_ack = 1'b1; ir_ready = 1'b1;
        br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
        next_cycle();
        br_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top: got %b/%h want 1/fffffffc", mem_req, mem_addr); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (ir_valid !== 1'b1 || ir_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_ir: got %b/%h want 1/fffffffc", ir_valid, ir_pc); end
        repeat (2 - QD) begin
            next_cycle();
            @(negedge clk);
        end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_zero: got %b/%h want 1/0", mem_req, mem_addr); end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        salt = $urandom; rst = 1'b0; mem_ack = 1'b1; ir_ready = 1'b0;
        next_cycle();
        mem_ack = 1'b0;
        next_cycle();
        rst = 1'b1; mem_ack = 1'b1; br_valid = 1'b1; br_target = 32'h200;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL mid_rst_req: got %b want 0", mem_req); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", ir_valid); end
        next_cycle();
        rst = 1'b0; mem_ack = 1'b0; br_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_bad++; $display("FAIL mid_restart: got %b/%h want 1/4", mem_req, mem_addr); end
        n_cmp++; if (ir_valid !== 1'b0 || ir_pc !== 32'h0) begin n_bad++; $display("FAIL mid_flush: got %b/%h want 0/0", ir_valid, ir_pc); end
        next_cycle();
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic [63:0] m_last;
        logic [31:0] m_fpc, m_daddr;
        logic        m_drain, exp_req, exp_valid;
        logic [31:0] exp_addr;
        do_reset();
        q.delete(); m_last = '0; m_fpc = 32'h4; m_daddr = '0; m_drain = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom % 64 == 0);
            br_valid  = ($urandom % 8 == 0);
            br_target = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            mem_ack   = ($urandom % 3 != 0);
            ir_ready  = ($urandom % 3 != 0);
            salt      = $urandom;
            @(negedge clk);
            exp_req   = !rst && (m_drain || q.size() < QD);
            exp_addr  = m_drain ? m_daddr : m_fpc;
            exp_valid = !rst && (q.size() != 0);
            n_cmp++; if (mem_req !== exp_req) begin n_bad++; $display("FAIL rnd_req cyc %0d: got %b want %b", c, mem_req, exp_req); end
            if (exp_req) begin
                n_cmp++; if (mem_addr !== exp_addr) begin n_bad++; $display("FAIL rnd_addr cyc %0d: got %h want %h", c, mem_addr, exp_addr); end
            end
            n_cmp++; if (ir_valid !== exp_valid) begin n_bad++; $display("FAIL rnd_valid cyc %0d: got %b want %b", c, ir_valid, exp_valid); end
            n_cmp++; if ({ir_pc, ir_data} !== m_last) begin n_bad++; $display("FAIL rnd_head cyc %0d: got %h want %h", c, {ir_pc, ir_data}, m_last); end
            if (rst) begin
                q.delete(); m_fpc = 32'h4; m_drain = 1'b0; m_last = '0;
            end else if (m_drain) begin
                if (br_valid) m_fpc = br_target & 32'hFFFF_FFFC;
                if (mem_ack) m_drain = 1'b0;
            end else if (br_valid) begin
                q.delete();
                if (exp_req && !mem_ack) begin
                    m_drain = 1'b1;
                    m_daddr = m_fpc;
                end
                m_fpc = br_target & 32'hFFFF_FFFC;
            end else begin
                if (ir_ready && q.size() != 0) void'(q.pop_front());
                if (exp_req && mem_ack) begin
                    q.push_back({m_fpc, word_at(m_fpc)});
                    m_fpc = m_fpc + 32'd4;
                end
            end
            if (q.size() != 0) m_last = q[0];
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; br_valid = 1'b0; br_target = '0; ir_ready = 1'b0; salt = '0;
        #1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_drain();
        test_branch_ack();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
